fetcher: RTL and testbench

- Instruction fetch stage of each core.
- Takes `current_pc` from the PC unit while the core scheduler is in `CORE_FETCH`, and returns one 16-bit instruction to the decoder.
- Small direct-mapped instruction buffer absorbs repeated fetches; misses go to program memory over a valid/ready read channel.
- Reports its own state so the scheduler can advance from FETCH to DECODE.

---
 rtl/fetcher.sv | 117 +++++++++++
 tb/tb_fetcher.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetcher.sv
// Instruction fetch stage: direct-mapped instruction buffer in front of a
// valid/ready program-memory read channel, one 16-bit instruction per fetch.
module fetcher #(
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
  parameter int unsigned PROGRAM_MEM_DATA_BITS = 16,
  parameter int unsigned CACHE_LINES           = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             invalidate,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic                             cache_hit
);

  localparam int unsigned ADDR_W = PROGRAM_MEM_ADDR_BITS;
  localparam int unsigned DATA_W = PROGRAM_MEM_DATA_BITS;
  localparam int unsigned IDX_W  = $clog2(CACHE_LINES);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_FETCHING = 3'b001,
    S_FETCHED  = 3'b010
  } state_t;

  state_t                  r_state;
  logic                    r_mem_valid;
  logic [ADDR_W-1:0]       r_addr;
  logic [DATA_W-1:0]       r_instr;
  logic                    r_hit;
  logic [CACHE_LINES-1:0]  r_line_valid;
  logic [TAG_W-1:0]        r_line_tag  [CACHE_LINES];
  logic [DATA_W-1:0]       r_line_data [CACHE_LINES];

  logic [IDX_W-1:0]        w_idx;
  logic [TAG_W-1:0]        w_tag;
  logic [IDX_W-1:0]        w_fill_idx;
  logic [TAG_W-1:0]        w_fill_tag;
  logic                    w_hit;

  // Lookup uses the live PC; fills use the address latched at request time.
  assign w_idx      = current_pc[IDX_W-1:0];
  assign w_tag      = current_pc[ADDR_W-1:IDX_W];
  assign w_fill_idx = r_addr[IDX_W-1:0];
  assign w_fill_tag = r_addr[ADDR_W-1:IDX_W];
  assign w_hit      = r_line_valid[w_idx] && (r_line_tag[w_idx] == w_tag) && !invalidate;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_mem_valid  <= 1'b0;
      r_addr       <= '0;
      r_instr      <= '0;
      r_hit        <= 1'b0;
      r_line_valid <= '0;
      for (int i = 0; i < int'(CACHE_LINES); i++) begin
        r_line_tag[i]  <= '0;
        r_line_data[i] <= '0;
      end
    end else begin
      r_hit <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable && (core_state == CORE_FETCH)) begin
            if (w_hit) begin
              r_instr <= r_line_data[w_idx];
              r_hit   <= 1'b1;
              r_state <= S_FETCHED;
            end else begin
              r_mem_valid <= 1'b1;
              r_addr      <= current_pc;
              r_state     <= S_FETCHING;
            end
          end
        end
        S_FETCHING: begin
          if (mem_read_ready) begin
            r_instr                  <= mem_read_data;
            r_mem_valid              <= 1'b0;
            r_line_valid[w_fill_idx] <= 1'b1;
            r_line_tag[w_fill_idx]   <= w_fill_tag;
            r_line_data[w_fill_idx]  <= mem_read_data;
            r_state                  <= S_FETCHED;
          end
        end
        S_FETCHED: begin
          if (core_state == CORE_DECODE) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Placed last so a coincident fill is not left valid.
      if (invalidate) begin
        r_line_valid <= '0;
      end
    end
  end

  assign mem_read_valid   = r_mem_valid;
  assign mem_read_address = r_addr;
  assign fetcher_state    = r_state;
  assign instruction      = r_instr;
  assign cache_hit        = r_hit;

endmodule

// File: tb/tb_fetcher.sv
// Randomized self-checking bench for fetcher against a line-occupancy model
// (which PC each buffer index currently holds) and a fixed memory image.
module tb_fetcher;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 16;
  localparam int unsigned LINES = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [2:0]    core_state;
  logic [AW-1:0] current_pc;
  logic          invalidate;
  logic          mem_read_valid;
  logic [AW-1:0] mem_read_address;
  logic          mem_read_ready;
  logic [DW-1:0] mem_read_data;
  logic [2:0]    fetcher_state;
  logic [DW-1:0] instruction;
  logic          cache_hit;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [256];
  bit            m_valid [LINES];
  int            m_pc    [LINES];

  fetcher #(
    .PROGRAM_MEM_ADDR_BITS(AW),
    .PROGRAM_MEM_DATA_BITS(DW),
    .CACHE_LINES(LINES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .core_state(core_state),
    .current_pc(current_pc),
    .invalidate(invalidate),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data),
    .fetcher_state(fetcher_state),
    .instruction(instruction),
    .cache_hit(cache_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(LINES); i++) m_valid[i] = 1'b0;
  endtask

  // One complete fetch from IDLE back to IDLE, checking every cycle.
  task automatic do_fetch(input int pc, input int delay, input bit inval_lookup,
                          input bit inval_fill, input bit drop_en);
    int  idx;
    bit  exp_hit;
    idx = pc % int'(LINES);
    exp_hit = m_valid[idx] && (m_pc[idx] == pc) && !inval_lookup;
    if (inval_lookup) model_clear();
    enable     = 1'b1;
    core_state = 3'b001;
    current_pc = AW'(pc);
    invalidate = inval_lookup;
    tick();
    invalidate = 1'b0;
    core_state = 3'b000;
    if (exp_hit) begin
      chk("hit_state", 32'(fetcher_state), 32'h2);
      chk("hit_pulse", 32'(cache_hit), 32'h1);
      chk("hit_instr", 32'(instruction), 32'(mem[pc]));
      chk("hit_noreq", 32'(mem_read_valid), 32'h0);
    end else begin
      chk("miss_state", 32'(fetcher_state), 32'h1);
      chk("miss_valid", 32'(mem_read_valid), 32'h1);
      chk("miss_addr", 32'(mem_read_address), 32'(pc));
      chk("miss_nohit", 32'(cache_hit), 32'h0);
      if (drop_en) enable = 1'b0;
      current_pc = AW'($urandom);
      for (int d = 0; d < delay; d++) begin
        mem_read_data = DW'($urandom);
        tick();
        chk("wait_valid", 32'(mem_read_valid), 32'h1);
        chk("wait_addr", 32'(mem_read_address), 32'(pc));
        chk("wait_state", 32'(fetcher_state), 32'h1);
      end
      mem_read_ready = 1'b1;
      mem_read_data  = mem[pc];
      invalidate     = inval_fill;
      tick();
      mem_read_ready = 1'b0;
      mem_read_data  = DW'($urandom);
      invalidate     = 1'b0;
      chk("fill_state", 32'(fetcher_state), 32'h2);
      chk("fill_instr", 32'(instruction), 32'(mem[pc]));
      chk("fill_valid", 32'(mem_read_valid), 32'h0);
      chk("fill_nohit", 32'(cache_hit), 32'h0);
      if (inval_fill) model_clear();
      else begin
        m_valid[idx] = 1'b1;
        m_pc[idx]    = pc;
      end
    end
    tick();
    chk("hold_state", 32'(fetcher_state), 32'h2);
    chk("hold_instr", 32'(instruction), 32'(mem[pc]));
    chk("hold_nohit", 32'(cache_hit), 32'h0);
    core_state = 3'b010;
    tick();
    core_state = 3'b000;
    enable     = 1'b1;
    chk("dec_idle", 32'(fetcher_state), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    mem[3] = 16'h3A41;
    model_clear();
    reset = 1'b0; enable = 1'b0; core_state = 3'b000; current_pc = '0;
    invalidate = 1'b0; mem_read_ready = 1'b0; mem_read_data = '0;
    tick();
    chk("rst_state", 32'(fetcher_state), 32'h0);
    chk("rst_valid", 32'(mem_read_valid), 32'h0);
    chk("rst_addr", 32'(mem_read_address), 32'h0);
    chk("rst_instr", 32'(instruction), 32'h0);
    chk("rst_hit", 32'(cache_hit), 32'h0);
    reset = 1'b1;
    tick();

    // Asynchronous reset while a request to 8'h05 is outstanding.
    do_fetch(5, 0, 0, 0, 0);
    enable = 1'b1; core_state = 3'b001; current_pc = 8'h05;
    tick();
    core_state = 3'b000;
    chk("pre_rst_valid", 32'(mem_read_valid), 32'h0);
    chk("pre_rst_state", 32'(fetcher_state), 32'h2);
    core_state = 3'b010;
    tick();
    core_state = 3'b000;
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    model_clear();
    core_state = 3'b001;
    tick();
    core_state = 3'b000;
    chk("mid_valid", 32'(mem_read_valid), 32'h1);
    chk("mid_addr", 32'(mem_read_address), 32'h05);
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(mem_read_valid), 32'h0);
    chk("arst_state", 32'(fetcher_state), 32'h0);
    chk("arst_instr", 32'(instruction), 32'h0);
    model_clear();
    tick();
    reset = 1'b1;
    tick();
    do_fetch(5, 1, 0, 0, 0);

    // Directed: cold miss, hit, alias, invalidate, enable gating.
    do_fetch(3, 2, 0, 0, 0);
    do_fetch(3, 0, 0, 0, 0);
    do_fetch(7, 1, 0, 0, 0);
    do_fetch(3, 0, 0, 0, 0);
    do_fetch(1, 0, 0, 0, 0);
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    model_clear();
    do_fetch(1, 1, 0, 0, 0);
    do_fetch(2, 1, 0, 1, 0);
    do_fetch(2, 0, 0, 0, 0);
    do_fetch(2, 0, 0, 0, 0);
    do_fetch(2, 0, 1, 0, 0);
    enable = 1'b0; core_state = 3'b001; current_pc = 8'h02;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("dis_state", 32'(fetcher_state), 32'h0);
      chk("dis_valid", 32'(mem_read_valid), 32'h0);
      chk("dis_hit", 32'(cache_hit), 32'h0);
    end
    core_state = 3'b000; enable = 1'b1;
    do_fetch(9, 3, 0, 0, 1);

    // Random mix over a small PC range so hits and aliases are frequent.
    for (int n = 0; n < 60; n++) begin
      do_fetch(int'($urandom_range(0, 11)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 9) == 0) begin
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        model_clear();
        chk("inv_idle", 32'(fetcher_state), 32'h0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
